// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 access codes and FSM states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store merge, load extension, misalign.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] shifted;
  logic [31:0] wrep;

  always_comb begin
    byte_en  = 4'b0000;
    wrep     = 32'h0;
    ld_data  = 32'h0;
    misalign = 1'b0;
    shifted  = rword >> {addr_lo, 3'b000};
    // funct3[2] selects zero-extension for the unsigned load variants
    case (funct3[1:0])
      F3_B[1:0]: begin
        byte_en = 4'b0001 << addr_lo;
        wrep    = {4{wdata[7:0]}};
        ld_data = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
      end
      F3_H[1:0]: begin
        misalign = addr_lo[0];
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        ld_data  = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
      end
      F3_W[1:0]: begin
        misalign = |addr_lo;
        byte_en  = 4'b1111;
        wrep     = wdata;
        ld_data  = rword;
      end
      default: ;
    endcase
    st_word = rword;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) st_word[i*8 +: 8] = wrep[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: accepts a request, waits WAIT_CYCLES, then answers once.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1; valid holds until then.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word;
  logic [3:0]    byte_en;
  logic [31:0]   st_word;
  logic [31:0]   ld_data;
  logic          misalign;
  logic          acc_err;
  logic          accept;
  logic          enter_resp;
  logic          mem_we;

  // With zero wait states the access happens on the accepting edge, so use the live request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_f3    = req_funct3;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_f3    = funct3_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign rd_word = mem[acc_idx];

  dmem_lane_fmt u_lane_fmt (
    .addr_lo  (acc_addr[1:0]),
    .funct3   (acc_f3),
    .wdata    (acc_wdata),
    .rword    (rd_word),
    .byte_en  (byte_en),
    .st_word  (st_word),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  always_comb begin
    acc_err = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111) || misalign
           || (acc_we && !((acc_f3 == F3_B) || (acc_f3 == F3_H) || (acc_f3 == F3_W)))
           || ({1'b0, acc_addr} >= ADDR_LIMIT);
  end

  assign accept     = (state_q == IDLE) && req_ready_q && req_valid;
  assign enter_resp = (accept && (WAIT_CYCLES == 0))
                   || ((state_q == WAIT) && (cnt_q == 4'(WAIT_CYCLES)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          funct3_d    = req_funct3;
          req_ready_d = 1'b0;
          state_d     = WAIT;
          cnt_d       = 4'd1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d     = RESP;
      cnt_d       = 4'd0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : ld_data;
      mem_we      = acc_we && !acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[acc_idx] <= st_word;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, backpressure/reset sequences, random vs byte model.
module tb_dmem_responder;

  localparam int WAIT_CYC = 2;
  localparam int DEPTH    = 1024;
  localparam int LAT      = WAIT_CYC + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] ref_mem [int unsigned];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  function automatic void add_vec(input string name, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  // Reference: byte-addressed memory, size from funct3, plain arithmetic for extension.
  function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    longint val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3 > 3'b010)
       || ((addr % size) != 0) || (addr >= 32'(DEPTH * 4));
    rd = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      val = 0;
      for (int i = size - 1; i >= 0; i--) val = val * 256 + longint'(ref_mem[addr + i]);
      if (f3 < 3'b100 && size < 4 && val >= (longint'(1) << (8*size - 1)))
        val = val - (longint'(1) << (8*size));
      rd = 32'(val);
    end
  endfunction

  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int guard;
    int lat;
    @(negedge clk);
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      timeout_fail({name, " accept"});
      req_valid = 1'b0; rsp_ready = 1'b1;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom_range(0, 1));
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      timeout_fail({name, " rsp"});
      rsp_ready = 1'b1;
      return;
    end
    chk({name, " lat"}, 32'(lat), 32'(LAT));
    chk({name, " rdata"}, rsp_rdata, exp_rd);
    chk({name, " err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " hold rdata"}, rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int lat;
    logic [31:0] rd;
    logic        er;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int r;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle req_ready", 32'(req_ready), 32'd1);

    add_vec("sw_10",    1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0);
    add_vec("lw_10",    0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);
    add_vec("sb_11",    1, 32'h11,  32'hFFFFFF80, 3'b000, 32'h0,        0);
    add_vec("lb_11",    0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 0);
    add_vec("lbu_11",   0, 32'h11,  32'h0,        3'b100, 32'h00000080, 0);
    add_vec("lw_10b",   0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 0);
    add_vec("lb_13",    0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 0);
    add_vec("lbu_12",   0, 32'h12,  32'h0,        3'b100, 32'h000000AD, 0);
    add_vec("sw_20",    1, 32'h20,  32'hA5A55AA5, 3'b010, 32'h0,        0);
    add_vec("sh_22",    1, 32'h22,  32'hFFFF1234, 3'b001, 32'h0,        0);
    add_vec("lh_22",    0, 32'h22,  32'h0,        3'b001, 32'h00001234, 0);
    add_vec("lhu_20",   0, 32'h20,  32'h0,        3'b101, 32'h00005AA5, 0);
    add_vec("lw_20",    0, 32'h20,  32'h0,        3'b010, 32'h12345AA5, 0);
    add_vec("sh_26",    1, 32'h26,  32'h00008001, 3'b001, 32'h0,        0);
    add_vec("lh_26",    0, 32'h26,  32'h0,        3'b001, 32'hFFFF8001, 0);
    add_vec("lhu_26",   0, 32'h26,  32'h0,        3'b101, 32'h00008001, 0);
    add_vec("lw_13",    0, 32'h13,  32'h0,        3'b010, 32'h0,        1);
    add_vec("sh_21",    1, 32'h21,  32'h0000BEEF, 3'b001, 32'h0,        1);
    add_vec("ld_f3_011",0, 32'h10,  32'h0,        3'b011, 32'h0,        1);
    add_vec("lw_1000",  0, 32'h1000,32'h0,        3'b010, 32'h0,        1);
    add_vec("st_f3_100",1, 32'h10,  32'h00000000, 3'b100, 32'h0,        1);
    add_vec("lw_fffc",  0, 32'hFFFFFFFC, 32'h0,   3'b010, 32'h0,        1);
    add_vec("sw_1010",  1, 32'h1010,32'h0BADF00D, 3'b010, 32'h0,        1);
    add_vec("lw_10c",   0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 0);
    add_vec("sw_ffc",   1, 32'hFFC, 32'h01020304, 3'b010, 32'h0,        0);
    add_vec("lw_ffc",   0, 32'hFFC, 32'h0,        3'b010, 32'h01020304, 0);
    add_vec("lb_fff",   0, 32'hFFF, 32'h0,        3'b000, 32'h00000001, 0);
    add_vec("sw_30",    1, 32'h30,  32'h11223344, 3'b010, 32'h0,        0);

    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
              vecs[i].exp_rd, vecs[i].exp_err, (i % 4 == 3) ? 2 : 0);

    // Backpressure: response held while a new request waits on the bus
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) timeout_fail("bp accept");
    @(negedge clk);
    req_addr = 32'h20;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("bp lat", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 32'(rsp_valid), 32'd1);
      chk("bp hold rdata", rsp_rdata, 32'hDEAD80EF);
      chk("bp hold req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release valid", 32'(rsp_valid), 32'd0);
    chk("bp release rdata", rsp_rdata, 32'h0);
    chk("bp release req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp second accepted", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("bp second lat", 32'(lat), 32'(LAT));
    chk("bp second rdata", rsp_rdata, 32'h12345AA5);

    // Reset during WAIT of a store: no response, no commit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_funct3 = 3'b010;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) timeout_fail("rst accept");
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst no rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst idle ready", 32'(req_ready), 32'd1);
    run_txn("lw_30 after rst", 0, 32'h30, 32'h0, 3'b010, 32'h11223344, 0, 0);

    // Random phase: initialise a 64-byte window, then mixed traffic against the byte model
    for (int i = 0; i < 16; i++) begin
      addr = 32'h400 + 32'(i * 4);
      wd = $urandom;
      ref_access(1'b1, addr, wd, 3'b010, rd, er);
      run_txn("rnd init", 1'b1, addr, wd, 3'b010, rd, er, 0);
    end
    for (int n = 0; n < 200; n++) begin
      we = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 15);
      if (r < 14) f3 = legal_f3[r % 5];
      else if (r == 14) f3 = 3'b011;
      else f3 = $urandom_range(0, 1) ? 3'b110 : 3'b111;
      r = $urandom_range(0, 19);
      if (r == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = $urandom | 32'h80000000;
      else addr = 32'h400 + 32'($urandom_range(0, 63));
      wd = $urandom;
      ref_access(we, addr, wd, f3, rd, er);
      run_txn("rnd", we, addr, wd, f3, rd, er, $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
